// File: rtl/pb_boot_ctrl.sv
// Boot sequencer: samples straps, launches the image loader, wakes the core, latches the EOC exit code.
// Optional boot-to-EOC cycle counter enabled by defining PB_BOOT_CTRL_CYCLE_CNT_EN.
module pb_boot_ctrl #(
  parameter int unsigned EntryWidth    = 64,
  parameter int unsigned TimeoutCycles = 2**20,
  parameter int unsigned CntWidth      = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            boot_mode_i,
  output logic                  ld_start_valid_o,
  input  logic                  ld_start_ready_i,
  output logic [1:0]            ld_src_o,
  input  logic                  ld_done_i,
  input  logic                  ld_err_i,
  input  logic [EntryWidth-1:0] ld_entry_i,
  output logic                  wake_valid_o,
  input  logic                  wake_ready_i,
  output logic [EntryWidth-1:0] wake_entry_o,
  input  logic                  eoc_we_i,
  input  logic [31:0]           eoc_wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           exit_code_o,
  output logic [1:0]            error_o,
  output logic [31:0]           cycles_o
);

  typedef enum logic [2:0] {
    ST_SAMPLE,
    ST_DISPATCH,
    ST_LAUNCH,
    ST_LOAD,
    ST_WAKE,
    ST_WAIT_EOC,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam bit                  TMO_EN   = (TimeoutCycles != 0);
  localparam logic [CntWidth-1:0] TMO_LAST = CntWidth'(TimeoutCycles - 1);

  state_t              state;
  logic [1:0]          mode_q;
  logic [CntWidth-1:0] tmo_cnt;

  // Straps are captured in SAMPLE and acted on one cycle later in DISPATCH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= ST_SAMPLE;
      mode_q           <= '0;
      tmo_cnt          <= '0;
      ld_start_valid_o <= 1'b0;
      ld_src_o         <= '0;
      wake_valid_o     <= 1'b0;
      wake_entry_o     <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      exit_code_o      <= '0;
      error_o          <= '0;
    end else begin
      case (state)
        ST_SAMPLE: begin
          mode_q <= boot_mode_i;
          busy_o <= 1'b1;
          state  <= ST_DISPATCH;
        end
        ST_DISPATCH: begin
          case (mode_q)
            2'd0: state <= ST_WAIT_EOC;
            2'd1: begin
              error_o <= 2'd1;
              busy_o  <= 1'b0;
              state   <= ST_ERROR;
            end
            default: begin
              ld_start_valid_o <= 1'b1;
              ld_src_o         <= mode_q;
              state            <= ST_LAUNCH;
            end
          endcase
        end
        ST_LAUNCH: begin
          if (ld_start_ready_i) begin
            ld_start_valid_o <= 1'b0;
            tmo_cnt          <= '0;
            state            <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Error beats done, done beats an expiring timeout.
          if (ld_err_i) begin
            error_o <= 2'd2;
            busy_o  <= 1'b0;
            state   <= ST_ERROR;
          end else if (ld_done_i) begin
            wake_entry_o <= ld_entry_i;
            wake_valid_o <= 1'b1;
            state        <= ST_WAKE;
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            error_o <= 2'd3;
            busy_o  <= 1'b0;
            state   <= ST_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + CntWidth'(1);
          end
        end
        ST_WAKE: begin
          if (wake_ready_i) begin
            wake_valid_o <= 1'b0;
            state        <= ST_WAIT_EOC;
          end
        end
        ST_WAIT_EOC: begin
          if (eoc_we_i && eoc_wdata_i[0]) begin
            done_o      <= 1'b1;
            exit_code_o <= {1'b0, eoc_wdata_i[31:1]};
            busy_o      <= 1'b0;
            state       <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PB_BOOT_CTRL_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
    end else if ((state != ST_SAMPLE) && (state != ST_DONE) && (state != ST_ERROR)
                 && (cyc_q != '1)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycles_o = cyc_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_pb_boot_ctrl.sv
// Scoreboard bench for pb_boot_ctrl: expected entry/exit/error values are queued at stimulus time.
module tb_pb_boot_ctrl;

  localparam int unsigned EW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [1:0]    boot_mode_i;
  logic          ld_start_valid_o;
  logic          ld_start_ready_i;
  logic [1:0]    ld_src_o;
  logic          ld_done_i;
  logic          ld_err_i;
  logic [EW-1:0] ld_entry_i;
  logic          wake_valid_o;
  logic          wake_ready_i;
  logic [EW-1:0] wake_entry_o;
  logic          eoc_we_i;
  logic [31:0]   eoc_wdata_i;
  logic          busy_o;
  logic          done_o;
  logic [31:0]   exit_code_o;
  logic [1:0]    error_o;
  logic [31:0]   cycles_o;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_entry[$];
  logic [31:0]   exp_exit[$];
  logic [1:0]    exp_err[$];

  always #5 clk_i = ~clk_i;

  pb_boot_ctrl #(.EntryWidth(EW), .TimeoutCycles(16), .CntWidth(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .boot_mode_i(boot_mode_i),
    .ld_start_valid_o(ld_start_valid_o), .ld_start_ready_i(ld_start_ready_i),
    .ld_src_o(ld_src_o), .ld_done_i(ld_done_i), .ld_err_i(ld_err_i),
    .ld_entry_i(ld_entry_i), .wake_valid_o(wake_valid_o), .wake_ready_i(wake_ready_i),
    .wake_entry_o(wake_entry_o), .eoc_we_i(eoc_we_i), .eoc_wdata_i(eoc_wdata_i),
    .busy_o(busy_o), .done_o(done_o), .exit_code_o(exit_code_o), .error_o(error_o),
    .cycles_o(cycles_o)
  );

  function automatic logic [135:0] all_outs();
    return {ld_start_valid_o, ld_src_o, wake_valid_o, wake_entry_o, busy_o, done_o,
            exit_code_o, error_o, cycles_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] mode);
    rst_ni = 1'b0;
    boot_mode_i = mode;
    ld_start_ready_i = 1'b0;
    ld_done_i = 1'b0;
    ld_err_i = 1'b0;
    ld_entry_i = '0;
    wake_ready_i = 1'b0;
    eoc_we_i = 1'b0;
    eoc_wdata_i = '0;
    repeat (2) tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(2'd2);
    rst_ni = 1'b0;
    #1;
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", all_outs());
    end
  endtask

  task automatic test_preload();
    logic saw_valid = 1'b0;
    logic [31:0] e;
    do_reset(2'd0);
    tick();
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL preload_busy got=%b want=1", busy_o); end
    tick();
    eoc_we_i = 1'b1; eoc_wdata_i = 32'h0000_0001; exp_exit.push_back(32'h0);
    tick();
    eoc_we_i = 1'b0;
    for (int i = 0; i < 20 && !done_o; i++) tick();
    total++;
    if (done_o !== 1'b1 || exp_exit.size() == 0) begin
      bad++; $display("FAIL preload_done got=%b want=1", done_o);
    end else begin
      e = exp_exit.pop_front();
      total++;
      if (exit_code_o !== e) begin bad++; $display("FAIL preload_exit got=%h want=%h", exit_code_o, e); end
    end
    for (int i = 0; i < 4; i++) begin
      saw_valid = saw_valid | ld_start_valid_o | wake_valid_o;
      tick();
    end
    total++;
    if ({error_o, busy_o, saw_valid} !== 4'b0) begin
      bad++; $display("FAIL preload_status got err=%0d busy=%b valid_seen=%b want 0/0/0", error_o, busy_o, saw_valid);
    end
`ifndef PB_BOOT_CTRL_CYCLE_CNT_EN
    total++;
    if (cycles_o !== 32'd0) begin bad++; $display("FAIL cycles_tied got=%0d want=0", cycles_o); end
`endif
  endtask

  task automatic test_spi_boot();
    logic [EW-1:0] ent;
    logic [31:0] e;
    do_reset(2'd2);
    tick(); tick();
    // stray EOC and done in LAUNCH must be ignored
    eoc_we_i = 1'b1; eoc_wdata_i = 32'h0000_0009; ld_done_i = 1'b1; ld_entry_i = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ld_start_valid_o !== 1'b1 || ld_src_o !== 2'd2) begin
        bad++; $display("FAIL launch_hold c%0d got v=%b src=%0d want 1/2", i, ld_start_valid_o, ld_src_o);
      end
      tick();
      eoc_we_i = 1'b0; ld_done_i = 1'b0;
    end
    ld_start_ready_i = 1'b1;
    tick();
    ld_start_ready_i = 1'b0;
    total++;
    if ({ld_start_valid_o, wake_valid_o, done_o, busy_o} !== 4'b0001) begin
      bad++; $display("FAIL after_start got v=%b wv=%b done=%b busy=%b want 0/0/0/1",
                      ld_start_valid_o, wake_valid_o, done_o, busy_o);
    end
    tick(); tick();
    ld_done_i = 1'b1; ld_entry_i = 64'h0000_0000_7000_0000; exp_entry.push_back(64'h7000_0000);
    tick();
    ld_done_i = 1'b0; ld_entry_i = '1;
    for (int i = 0; i < 20 && !wake_valid_o; i++) tick();
    total++;
    if (wake_valid_o !== 1'b1 || exp_entry.size() == 0) begin
      bad++; $display("FAIL wake_valid got=%b want=1", wake_valid_o);
    end else begin
      ent = exp_entry.pop_front();
      tick(); tick();
      total++;
      if (wake_valid_o !== 1'b1 || wake_entry_o !== ent) begin
        bad++; $display("FAIL wake_entry got v=%b e=%h want 1/%h", wake_valid_o, wake_entry_o, ent);
      end
      wake_ready_i = 1'b1;
      tick();
      wake_ready_i = 1'b0;
      total++;
      if (wake_valid_o !== 1'b0 || wake_entry_o !== ent) begin
        bad++; $display("FAIL wake_after got v=%b e=%h want 0/%h", wake_valid_o, wake_entry_o, ent);
      end
    end
    eoc_we_i = 1'b1; eoc_wdata_i = 32'h0000_0055; exp_exit.push_back(32'h2A);
    tick();
    eoc_we_i = 1'b1; eoc_wdata_i = 32'h0000_0011;
    tick();
    eoc_we_i = 1'b0;
    for (int i = 0; i < 20 && !done_o; i++) tick();
    total++;
    if (done_o !== 1'b1 || exp_exit.size() == 0) begin
      bad++; $display("FAIL spi_done got=%b want=1", done_o);
    end else begin
      e = exp_exit.pop_front();
      total++;
      if (exit_code_o !== e || error_o !== 2'd0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL spi_exit got=%h err=%0d busy=%b want %h/0/0", exit_code_o, error_o, busy_o, e);
      end
    end
  endtask

  task automatic test_unsupported();
    logic saw_valid = 1'b0;
    do_reset(2'd1);
    tick();
    total++;
    if (error_o !== 2'd0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL sd_early got err=%0d busy=%b want 0/1", error_o, busy_o);
    end
    tick();
    exp_err.push_back(2'd1);
    total++;
    if (error_o !== exp_err.pop_front() || busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL sd_error got err=%0d busy=%b done=%b want 1/0/0", error_o, busy_o, done_o);
    end
    for (int i = 0; i < 5; i++) begin
      saw_valid = saw_valid | ld_start_valid_o;
      tick();
    end
    total++;
    if (saw_valid !== 1'b0 || error_o !== 2'd1) begin
      bad++; $display("FAIL sd_sticky got valid_seen=%b err=%0d want 0/1", saw_valid, error_o);
    end
  endtask

  task automatic launch_i2c();
    do_reset(2'd3);
    tick(); tick();
    total++;
    if (ld_start_valid_o !== 1'b1 || ld_src_o !== 2'd3) begin
      bad++; $display("FAIL i2c_launch got v=%b src=%0d want 1/3", ld_start_valid_o, ld_src_o);
    end
    ld_start_ready_i = 1'b1;
    tick();
    ld_start_ready_i = 1'b0;
  endtask

  task automatic test_timeout();
    launch_i2c();
    exp_err.push_back(2'd3);
    repeat (15) tick();
    total++;
    if (error_o !== 2'd0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL tmo_early got err=%0d busy=%b want 0/1", error_o, busy_o);
    end
    tick();
    total++;
    if (error_o !== exp_err.pop_front() || busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL tmo_error got err=%0d busy=%b done=%b want 3/0/0", error_o, busy_o, done_o);
    end
    ld_done_i = 1'b1;
    tick();
    ld_done_i = 1'b0;
    tick();
    total++;
    if (wake_valid_o !== 1'b0 || error_o !== 2'd3) begin
      bad++; $display("FAIL tmo_sticky got wv=%b err=%0d want 0/3", wake_valid_o, error_o);
    end
  endtask

  task automatic test_err_priority();
    launch_i2c();
    repeat (3) tick();
    ld_done_i = 1'b1; ld_err_i = 1'b1; ld_entry_i = 64'h1234; exp_err.push_back(2'd2);
    tick();
    ld_done_i = 1'b0; ld_err_i = 1'b0;
    for (int i = 0; i < 20 && error_o == 2'd0; i++) tick();
    total++;
    if (error_o !== exp_err.pop_front() || wake_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL err_prio got err=%0d wv=%b busy=%b want 2/0/0", error_o, wake_valid_o, busy_o);
    end
  endtask

  task automatic test_ignore_and_midreset();
    logic [31:0] e;
    do_reset(2'd0);
    tick(); tick();
    eoc_we_i = 1'b1; eoc_wdata_i = 32'h0000_0004;
    tick();
    eoc_we_i = 1'b0;
    tick();
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL eoc_bit0_clear got done=%b busy=%b want 0/1", done_o, busy_o);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if (all_outs() !== '0) begin bad++; $display("FAIL midreset got=%h want=0", all_outs()); end
    do_reset(2'd0);
    tick(); tick();
    eoc_we_i = 1'b1; eoc_wdata_i = 32'h0000_0003; exp_exit.push_back(32'h1);
    tick();
    eoc_we_i = 1'b0;
    for (int i = 0; i < 20 && !done_o; i++) tick();
    total++;
    if (done_o !== 1'b1 || exp_exit.size() == 0) begin
      bad++; $display("FAIL resample_done got=%b want=1", done_o);
    end else begin
      e = exp_exit.pop_front();
      total++;
      if (exit_code_o !== e) begin bad++; $display("FAIL resample_exit got=%h want=%h", exit_code_o, e); end
    end
  endtask

`ifdef PB_BOOT_CTRL_CYCLE_CNT_EN
  task automatic test_cycle_cnt();
    do_reset(2'd0);
    tick();
    repeat (9) tick();
    eoc_we_i = 1'b1; eoc_wdata_i = 32'h0000_0001;
    tick();
    eoc_we_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || cycles_o !== 32'd10) begin
      bad++; $display("FAIL cycles_at_eoc got done=%b cyc=%0d want 1/10", done_o, cycles_o);
    end
    repeat (5) tick();
    total++;
    if (cycles_o !== 32'd10) begin bad++; $display("FAIL cycles_hold got=%0d want=10", cycles_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_preload();
    test_spi_boot();
    test_unsupported();
    test_timeout();
    test_err_priority();
    test_ignore_and_midreset();
`ifdef PB_BOOT_CTRL_CYCLE_CNT_EN
    test_cycle_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
